// File: rtl/bit_count_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_count_seq : multi-cycle zeros/ones/leading/trailing-zero counter, CHUNK bits per clock
// Revision 1.0
// ---------------------------------------------------------------------------
module bit_count_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic             seen_q, seen_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    count_q, count_d;

  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    ones;
  logic [CW-1:0]    lead;
  logic             found;
  logic [CW-1:0]    add;
  logic [WIDTH-1:0] data_rev;

  always_comb begin
    data_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      data_rev[i] = data_in[WIDTH-1-i];
    end
  end

  // Per-chunk statistics, scanned MSB-first so "lead" stops at the first one.
  always_comb begin
    chunk = shreg_q[WIDTH-1 -: CHUNK];
    ones  = '0;
    lead  = '0;
    found = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      ones = ones + CW'(chunk[i]);
      if (!found) begin
        if (chunk[i]) begin
          found = 1'b1;
        end else begin
          lead = lead + CW'(1);
        end
      end
    end
  end

  always_comb begin
    case (mode_q)
      2'b00:   add = CW'(CHUNK) - ones;
      2'b01:   add = ones;
      default: add = seen_q ? '0 : lead;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    seen_d  = seen_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode;
          // Trailing zeros of the word are the leading zeros of its mirror image.
          shreg_d = (mode == 2'b11) ? data_rev : data_in;
          acc_d   = '0;
          seen_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        acc_d   = acc_q + add;
        seen_d  = seen_q | (|chunk);
        shreg_d = shreg_q << CHUNK;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(N - 1)) begin
          state_d = ST_DONE;
          count_d = acc_q + add;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'b00;
      shreg_q <= '0;
      acc_q   <= '0;
      seen_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      seen_q  <= seen_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_count_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bit_count_seq : directed bench for bit_count_seq at several WIDTH/CHUNK points
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_bit_count_seq;

  logic clk = 1'b0;
  logic rst;

  // 8-bit stimulus shared by three instances: CHUNK=2 (a), CHUNK=1 (c), CHUNK=8 (d)
  logic       start8;
  logic [1:0] mode8;
  logic [7:0] data8;
  logic       busy_a, done_a, busy_c, done_c, busy_d, done_d;
  logic [3:0] count_a, count_c, count_d;

  logic        start32;
  logic [1:0]  mode32;
  logic [31:0] data32;
  logic        busy_b, done_b;
  logic [5:0]  count_b;

  int compared   = 0;
  int mismatched = 0;

  // Results of the last 8-bit operation, index 0=a, 1=c, 2=d
  int         lat8 [3];
  int         nd8  [3];
  logic [3:0] cnt8 [3];
  logic       bsy8 [3];
  int         exp_lat8 [3] = '{4, 8, 1};

  int          lat32, nd32;
  logic [5:0]  cnt32;

  always #5 clk = ~clk;

  bit_count_seq #(.WIDTH(8), .CHUNK(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .data_in(data8),
    .busy(busy_a), .done(done_a), .count(count_a)
  );
  bit_count_seq #(.WIDTH(8), .CHUNK(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .data_in(data8),
    .busy(busy_c), .done(done_c), .count(count_c)
  );
  bit_count_seq #(.WIDTH(8), .CHUNK(8)) u_dut_d (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .data_in(data8),
    .busy(busy_d), .done(done_d), .count(count_d)
  );
  bit_count_seq #(.WIDTH(32), .CHUNK(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start32), .mode(mode32), .data_in(data32),
    .busy(busy_b), .done(done_b), .count(count_b)
  );

  function automatic int model32(input logic [31:0] d, input logic [1:0] m);
    int n;
    n = 0;
    case (m)
      2'b00: for (int i = 0; i < 32; i++) if (!d[i]) n++;
      2'b01: for (int i = 0; i < 32; i++) if (d[i]) n++;
      2'b10: begin
        for (int i = 31; i >= 0; i--) begin
          if (d[i]) break;
          n++;
        end
      end
      default: begin
        for (int i = 0; i < 32; i++) begin
          if (d[i]) break;
          n++;
        end
      end
    endcase
    return n;
  endfunction

  // Called at a negedge; returns at a negedge. Start sampled at the next edge.
  task automatic op8(input logic [7:0] d, input logic [1:0] m);
    data8  = d;
    mode8  = m;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    data8  = ~d;
    mode8  = ~m;
    bsy8[0] = busy_a; bsy8[1] = busy_c; bsy8[2] = busy_d;
    for (int j = 0; j < 3; j++) begin
      lat8[j] = 0; nd8[j] = 0; cnt8[j] = '0;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done_a) begin nd8[0]++; if (lat8[0] == 0) begin lat8[0] = c; cnt8[0] = count_a; end end
      if (done_c) begin nd8[1]++; if (lat8[1] == 0) begin lat8[1] = c; cnt8[1] = count_c; end end
      if (done_d) begin nd8[2]++; if (lat8[2] == 0) begin lat8[2] = c; cnt8[2] = count_d; end end
    end
  endtask

  task automatic op32(input logic [31:0] d, input logic [1:0] m);
    data32  = d;
    mode32  = m;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    data32  = ~d;
    mode32  = ~m;
    lat32 = 0; nd32 = 0; cnt32 = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done_b) begin
        nd32++;
        if (lat32 == 0) begin lat32 = c; cnt32 = count_b; end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start8 = 1'b0; mode8 = 2'b00; data8 = '0;
    start32 = 1'b0; mode32 = 2'b00; data32 = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy_a, done_a, count_a, busy_c, done_c, count_c, busy_d, done_d, count_d} !== 18'd0) begin
      mismatched++;
      $display("FAIL reset_8bit: got busy/done/count a=%b/%b/%0d c=%b/%b/%0d d=%b/%b/%0d, expected all 0",
               busy_a, done_a, count_a, busy_c, done_c, count_c, busy_d, done_d, count_d);
    end
    compared++;
    if ({busy_b, done_b, count_b} !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_32bit: got busy=%b done=%b count=%0d, expected 0/0/0", busy_b, done_b, count_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Checks every 8-bit instance against one expected count.
  task automatic test_op8(input string name, input logic [7:0] d, input logic [1:0] m, input int exp);
    op8(d, m);
    for (int j = 0; j < 3; j++) begin
      compared++;
      if (cnt8[j] !== 4'(exp)) begin
        mismatched++;
        $display("FAIL %s count dut%0d: got %0d expected %0d", name, j, cnt8[j], exp);
      end
      compared++;
      if (lat8[j] != exp_lat8[j]) begin
        mismatched++;
        $display("FAIL %s latency dut%0d: got %0d expected %0d", name, j, lat8[j], exp_lat8[j]);
      end
      compared++;
      if (nd8[j] != 1) begin
        mismatched++;
        $display("FAIL %s done_pulses dut%0d: got %0d expected 1", name, j, nd8[j]);
      end
      compared++;
      if (bsy8[j] !== 1'b1) begin
        mismatched++;
        $display("FAIL %s busy_after_start dut%0d: got %b expected 1", name, j, bsy8[j]);
      end
    end
  endtask

  task automatic test_zero_one;
    test_op8("zeros_A6", 8'b1010_0110, 2'b00, 4);
    test_op8("ones_A6",  8'b1010_0110, 2'b01, 4);
  endtask

  task automatic test_lead_trail;
    test_op8("lead_14",   8'b0001_0100, 2'b10, 3);
    test_op8("trail_14",  8'b0001_0100, 2'b11, 2);
    test_op8("lead_00",   8'h00,        2'b10, 8);
    test_op8("trail_00",  8'h00,        2'b11, 8);
  endtask

  task automatic test_reset_mid_scan;
    int ndone;
    test_op8("zeros_00", 8'h00, 2'b00, 8);
    data8 = 8'hA5; mode8 = 2'b01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({busy_a, done_a, count_a, busy_c, done_c, count_c} !== 12'd0) begin
      mismatched++;
      $display("FAIL reset_mid_scan: got a=%b/%b/%0d c=%b/%b/%0d, expected busy/done/count 0",
               busy_a, done_a, count_a, busy_c, done_c, count_c);
    end
    compared++;
    if (count_d !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_mid_scan count_d: got %0d expected 0", count_d);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a || done_c || done_d) ndone++;
    end
    compared++;
    if (ndone != 0) begin
      mismatched++;
      $display("FAIL reset_mid_scan no_done: got %0d done cycles expected 0", ndone);
    end
    test_op8("zeros_FF", 8'hFF, 2'b00, 0);
  endtask

  task automatic test_corners;
    test_op8("lead_FF",  8'hFF, 2'b10, 0);
    test_op8("ones_FF",  8'hFF, 2'b01, 8);
    test_op8("trail_80", 8'h80, 2'b11, 7);
    test_op8("lead_01",  8'h01, 2'b10, 7);
  endtask

  task automatic test_sweep;
    logic [31:0] d;
    int exp;
    for (int v = 0; v < 1512; v++) begin
      d = (v < 512) ? 32'(v) : 32'($urandom);
      for (int m = 0; m < 4; m++) begin
        op32(d, 2'(m));
        exp = model32(d, 2'(m));
        compared++;
        if (cnt32 !== 6'(exp)) begin
          mismatched++;
          $display("FAIL sweep count d=%h m=%0d: got %0d expected %0d", d, m, cnt32, exp);
        end
        compared++;
        if (lat32 != 8 || nd32 != 1) begin
          mismatched++;
          $display("FAIL sweep timing d=%h m=%0d: got latency %0d pulses %0d expected 8 and 1",
                   d, m, lat32, nd32);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int ndone, first_lat;
    logic [5:0] first_cnt;
    ndone = 0; first_lat = 0; first_cnt = '0;
    data32 = 32'h0000_00F0; mode32 = 2'b11; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (done_b) begin
        ndone++;
        if (first_lat == 0) begin first_lat = c; first_cnt = count_b; end
      end
      if (c == 3) begin start32 = 1'b1; data32 = 32'hFFFF_FFFF; mode32 = 2'b01; end
      if (c == 4) start32 = 1'b0;
      if (c == 8) begin start32 = 1'b1; data32 = 32'h0000_0000; mode32 = 2'b00; end
      if (c == 9) start32 = 1'b0;
    end
    compared++;
    if (ndone != 1) begin
      mismatched++;
      $display("FAIL start_while_busy pulses: got %0d expected 1", ndone);
    end
    compared++;
    if (first_cnt !== 6'd4 || first_lat != 8) begin
      mismatched++;
      $display("FAIL start_while_busy result: got count %0d latency %0d expected 4 and 8",
               first_cnt, first_lat);
    end
    compared++;
    if (count_b !== 6'd4 || busy_b !== 1'b0) begin
      mismatched++;
      $display("FAIL start_while_busy hold: got count %0d busy %b expected 4 and 0", count_b, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_zero_one();
    test_lead_trail();
    test_reset_mid_scan();
    test_corners();
    test_sweep();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
